// File: rtl/binary_clock_pkg.sv
`default_nettype none
// binary_clock_pkg: mode encodings, field widths and limits for the binary clock.
// Revision 1.0
package binary_clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_SET_HR  = 2'b01,
    MODE_SET_MIN = 2'b10
  } mode_t;

  localparam int SEC_W = 6;
  localparam int MIN_W = 6;
  localparam int HR_W  = 5;

  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
  localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;

  function automatic logic [5:0] wrap_inc(input logic [5:0] value, input logic [5:0] max);
    return (value == max) ? 6'd0 : value + 6'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clock_set_ctrl_if.sv
`default_nettype none
// clock_set_ctrl_if: button inputs and time/display outputs of the clock controller.
// Revision 1.0
interface clock_set_ctrl_if;
  import binary_clock_pkg::*;

  logic             btn_mode;
  logic             btn_inc;
  logic [SEC_W-1:0] seconds;
  logic [MIN_W-1:0] minutes;
  logic [HR_W-1:0]  hours;
  logic [1:0]       mode;
  logic             blink;
  logic             tick_1hz;

  modport master (
    output btn_mode, btn_inc,
    input  seconds, minutes, hours, mode, blink, tick_1hz
  );

  modport slave (
    input  btn_mode, btn_inc,
    output seconds, minutes, hours, mode, blink, tick_1hz
  );

endinterface
`default_nettype wire

// File: rtl/clock_set_ctrl_tick_gen.sv
`default_nettype none
// tick_gen: modulo-N counter with synchronous clear, hold-enable and terminal-count pulse.
// Revision 1.0
module tick_gen #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic term
);

  localparam int W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] count;

  assign term = en && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= term ? '0 : count + W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/clock_set_ctrl.sv
`default_nettype none
// clock_set_ctrl: 1 Hz timekeeping chain with button-driven hour/minute setting and blink.
// Revision 1.0 -- optional macro AUTO_REPEAT_EN adds hold-to-repeat on btn_inc.
module clock_set_ctrl
  import binary_clock_pkg::*;
#(
  parameter int CLK_HZ = 100000000
) (
  input  logic           clk_100MHz,
  input  logic           reset,
  clock_set_ctrl_if.slave bus
);

  localparam int BLINK_N = (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;

  mode_t            state_q;
  mode_t            state_d;
  logic             mode_prev;
  logic             inc_prev;
  logic             mode_edge;
  logic             inc_edge;
  logic             mode_change;
  logic             run;
  logic             in_set;
  logic             tick;
  logic             blink_term;
  logic             blink_q;
  logic             rep_inc;
  logic             inc_pulse;
  logic [SEC_W-1:0] seconds_q;
  logic [MIN_W-1:0] minutes_q;
  logic [HR_W-1:0]  hours_q;

  // History resets high so a button held through reset never looks like a press.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      mode_prev <= 1'b1;
      inc_prev  <= 1'b1;
    end else begin
      mode_prev <= bus.btn_mode;
      inc_prev  <= bus.btn_inc;
    end
  end

  assign mode_edge = bus.btn_mode & ~mode_prev;
  assign inc_edge  = bus.btn_inc & ~inc_prev & ~mode_edge;

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q <= MODE_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MODE_RUN:     if (mode_edge) state_d = MODE_SET_HR;
      MODE_SET_HR:  if (mode_edge) state_d = MODE_SET_MIN;
      MODE_SET_MIN: if (mode_edge) state_d = MODE_RUN;
      default:      state_d = MODE_RUN;
    endcase
  end

  assign mode_change = (state_d != state_q);
  assign run         = (state_q == MODE_RUN);
  assign in_set      = (state_q == MODE_SET_HR) || (state_q == MODE_SET_MIN);

  tick_gen #(.N(CLK_HZ)) u_prescaler (
    .clk  (clk_100MHz),
    .rst  (reset),
    .clr  (~run | mode_change),
    .en   (run),
    .term (tick)
  );

  tick_gen #(.N(BLINK_N)) u_blink_timer (
    .clk  (clk_100MHz),
    .rst  (reset),
    .clr  (~in_set | mode_change),
    .en   (in_set),
    .term (blink_term)
  );

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      blink_q <= 1'b0;
    end else if (mode_change) begin
      blink_q <= (state_d != MODE_RUN);
    end else if (!in_set) begin
      blink_q <= 1'b0;
    end else if (blink_term) begin
      blink_q <= ~blink_q;
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int REP_FIRST_N = (CLK_HZ / 2 > 0) ? CLK_HZ / 2 : 1;
  localparam int REP_NEXT_N  = (CLK_HZ / 8 > 0) ? CLK_HZ / 8 : 1;

  logic held;
  logic rep_fast;
  logic first_term;
  logic next_term;

  // Held means the press edge has already been consumed and the button stays down.
  assign held = in_set & bus.btn_inc & inc_prev & ~mode_edge;

  tick_gen #(.N(REP_FIRST_N)) u_rep_first (
    .clk  (clk_100MHz),
    .rst  (reset),
    .clr  (~held),
    .en   (held & ~rep_fast),
    .term (first_term)
  );

  tick_gen #(.N(REP_NEXT_N)) u_rep_next (
    .clk  (clk_100MHz),
    .rst  (reset),
    .clr  (~held),
    .en   (held & rep_fast),
    .term (next_term)
  );

  always_ff @(posedge clk_100MHz) begin
    if (reset || !held) begin
      rep_fast <= 1'b0;
    end else if (first_term) begin
      rep_fast <= 1'b1;
    end
  end

  assign rep_inc = first_term | next_term;
`else
  assign rep_inc = 1'b0;
`endif

  assign inc_pulse = (inc_edge | rep_inc) & in_set;

  // Later assignments win: the seconds clear on SET_HR entry overrides a coincident tick.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      seconds_q <= '0;
      minutes_q <= '0;
      hours_q   <= '0;
    end else begin
      if (tick) begin
        seconds_q <= wrap_inc(seconds_q, SEC_MAX);
        if (seconds_q == SEC_MAX) begin
          minutes_q <= wrap_inc(minutes_q, MIN_MAX);
          if (minutes_q == MIN_MAX) begin
            hours_q <= HR_W'(wrap_inc({1'b0, hours_q}, {1'b0, HR_MAX}));
          end
        end
      end
      if (mode_change && (state_d == MODE_SET_HR)) begin
        seconds_q <= '0;
      end
      if (inc_pulse && (state_q == MODE_SET_HR)) begin
        hours_q <= HR_W'(wrap_inc({1'b0, hours_q}, {1'b0, HR_MAX}));
      end
      if (inc_pulse && (state_q == MODE_SET_MIN)) begin
        minutes_q <= wrap_inc(minutes_q, MIN_MAX);
      end
    end
  end

  assign bus.seconds  = seconds_q;
  assign bus.minutes  = minutes_q;
  assign bus.hours    = hours_q;
  assign bus.mode     = state_q;
  assign bus.blink    = blink_q;
  assign bus.tick_1hz = tick;

endmodule
`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
`default_nettype none
// tb_clock_set_ctrl: directed self-checking bench for clock_set_ctrl with CLK_HZ = 8.
// Revision 1.0
module tb_clock_set_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  clock_set_ctrl_if bus ();

  clock_set_ctrl #(.CLK_HZ(8)) dut (
    .clk_100MHz (clk),
    .reset      (reset),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_mode();
    bus.btn_mode = 1'b1;
    step();
    bus.btn_mode = 1'b0;
    step();
  endtask

  task automatic press_inc(input int n);
    repeat (n) begin
      bus.btn_inc = 1'b1;
      step();
      bus.btn_inc = 1'b0;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    repeat (3) step();
    total_cnt++;
    if ({bus.hours, bus.minutes, bus.seconds} !== 17'd0)
      $display("FAIL reset_time: got %0d:%0d:%0d expected 0:0:0", bus.hours, bus.minutes, bus.seconds);
    else pass_cnt++;
    total_cnt++;
    if ({bus.mode, bus.blink, bus.tick_1hz} !== 4'd0)
      $display("FAIL reset_ctrl: got mode=%0d blink=%0d tick=%0d expected 0/0/0", bus.mode, bus.blink, bus.tick_1hz);
    else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_tick();
    bit quiet = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (bus.tick_1hz !== 1'b0 || bus.seconds !== 6'd0) quiet = 1'b0;
    end
    total_cnt++;
    if (!quiet) $display("FAIL pre_tick_quiet: got activity before cycle 8 expected none");
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.tick_1hz !== 1'b1) $display("FAIL tick_pulse: got %0d expected 1", bus.tick_1hz);
    else pass_cnt++;
    total_cnt++;
    if (bus.seconds !== 6'd0) $display("FAIL seconds_before_tick: got %0d expected 0", bus.seconds);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.seconds !== 6'd1) $display("FAIL seconds_after_tick: got %0d expected 1", bus.seconds);
    else pass_cnt++;
    total_cnt++;
    if (bus.tick_1hz !== 1'b0) $display("FAIL tick_single: got %0d expected 0", bus.tick_1hz);
    else pass_cnt++;
  endtask

  task automatic test_set_hours();
    bit exp_blink [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    bus.btn_mode = 1'b1;
    step();
    total_cnt++;
    if (bus.mode !== 2'b01) $display("FAIL enter_set_hr_mode: got %0d expected 1", bus.mode);
    else pass_cnt++;
    total_cnt++;
    if (bus.seconds !== 6'd0) $display("FAIL enter_set_hr_seconds: got %0d expected 0", bus.seconds);
    else pass_cnt++;
    total_cnt++;
    if (bus.blink !== 1'b1) $display("FAIL enter_set_hr_blink: got %0d expected 1", bus.blink);
    else pass_cnt++;
    bus.btn_mode = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      total_cnt++;
      if (bus.blink !== exp_blink[i] || bus.tick_1hz !== 1'b0)
        $display("FAIL blink_cycle_%0d: got blink=%0d tick=%0d expected blink=%0d tick=0",
                 i, bus.blink, bus.tick_1hz, exp_blink[i]);
      else pass_cnt++;
    end
    press_inc(22);
    total_cnt++;
    if (bus.hours !== 5'd22) $display("FAIL hours_preload: got %0d expected 22", bus.hours);
    else pass_cnt++;
    press_inc(3);
    total_cnt++;
    if (bus.hours !== 5'd1) $display("FAIL hours_wrap: got %0d expected 1", bus.hours);
    else pass_cnt++;
    total_cnt++;
    if (bus.minutes !== 6'd0) $display("FAIL minutes_untouched_in_set_hr: got %0d expected 0", bus.minutes);
    else pass_cnt++;
  endtask

  task automatic test_set_minutes();
    press_mode();
    total_cnt++;
    if (bus.mode !== 2'b10) $display("FAIL enter_set_min_mode: got %0d expected 2", bus.mode);
    else pass_cnt++;
    total_cnt++;
    if (bus.blink !== 1'b1) $display("FAIL set_min_blink_restart: got %0d expected 1", bus.blink);
    else pass_cnt++;
    press_inc(59);
    total_cnt++;
    if (bus.minutes !== 6'd59) $display("FAIL minutes_preload: got %0d expected 59", bus.minutes);
    else pass_cnt++;
    press_inc(1);
    total_cnt++;
    if ({bus.hours, bus.minutes} !== {5'd1, 6'd0})
      $display("FAIL minutes_wrap_no_carry: got %0d:%0d expected 1:0", bus.hours, bus.minutes);
    else pass_cnt++;
    press_inc(5);
    bus.btn_mode = 1'b1;
    bus.btn_inc  = 1'b1;
    step();
    total_cnt++;
    if (bus.mode !== 2'b00) $display("FAIL simultaneous_mode: got %0d expected 0", bus.mode);
    else pass_cnt++;
    total_cnt++;
    if (bus.minutes !== 6'd5) $display("FAIL simultaneous_inc_dropped: got %0d expected 5", bus.minutes);
    else pass_cnt++;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    step();
    total_cnt++;
    if (bus.blink !== 1'b0) $display("FAIL run_blink: got %0d expected 0", bus.blink);
    else pass_cnt++;
  endtask

  task automatic test_rollover();
    bit steady = 1'b1;
    press_mode();
    press_inc(22);
    press_mode();
    press_inc(54);
    total_cnt++;
    if ({bus.hours, bus.minutes, bus.seconds} !== {5'd23, 6'd59, 6'd0})
      $display("FAIL preload_2359: got %0d:%0d:%0d expected 23:59:0", bus.hours, bus.minutes, bus.seconds);
    else pass_cnt++;
    bus.btn_mode = 1'b1;
    step();
    bus.btn_mode = 1'b0;
    total_cnt++;
    if (bus.mode !== 2'b00) $display("FAIL back_to_run: got %0d expected 0", bus.mode);
    else pass_cnt++;
    for (int k = 1; k <= 60; k++) begin
      repeat (8) step();
      if (k < 60 && {bus.hours, bus.minutes, bus.seconds} !== {5'd23, 6'd59, 6'(k)}) steady = 1'b0;
    end
    total_cnt++;
    if (!steady) $display("FAIL rollover_intermediate: got a wrong time before tick 60 expected 23:59:ss");
    else pass_cnt++;
    total_cnt++;
    if ({bus.hours, bus.minutes, bus.seconds} !== 17'd0)
      $display("FAIL rollover_midnight: got %0d:%0d:%0d expected 0:0:0", bus.hours, bus.minutes, bus.seconds);
    else pass_cnt++;
  endtask

  task automatic test_hold_through_reset();
    reset = 1'b1;
    bus.btn_mode = 1'b1;
    bus.btn_inc  = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    repeat (2) step();
    total_cnt++;
    if (bus.mode !== 2'b00) $display("FAIL mode_held_through_reset: got %0d expected 0", bus.mode);
    else pass_cnt++;
    bus.btn_mode = 1'b0;
    step();
    bus.btn_mode = 1'b1;
    step();
    total_cnt++;
    if (bus.mode !== 2'b01) $display("FAIL enter_set_hr_after_reset: got %0d expected 1", bus.mode);
    else pass_cnt++;
    total_cnt++;
    if (bus.hours !== 5'd0) $display("FAIL inc_held_through_reset: got %0d expected 0", bus.hours);
    else pass_cnt++;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    step();
  endtask

  task automatic test_held_inc();
    int exp_hours;
`ifdef AUTO_REPEAT_EN
    exp_hours = 9;
`else
    exp_hours = 1;
`endif
    bus.btn_inc = 1'b1;
    repeat (12) step();
    bus.btn_inc = 1'b0;
    step();
    total_cnt++;
    if (bus.hours !== 5'(exp_hours)) $display("FAIL held_inc_hours: got %0d expected %0d", bus.hours, exp_hours);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_set();
    press_inc(3);
    total_cnt++;
    if (bus.mode !== 2'b01) $display("FAIL still_set_hr: got %0d expected 1", bus.mode);
    else pass_cnt++;
    reset = 1'b1;
    step();
    total_cnt++;
    if ({bus.hours, bus.minutes, bus.seconds} !== 17'd0)
      $display("FAIL reset_mid_set_time: got %0d:%0d:%0d expected 0:0:0", bus.hours, bus.minutes, bus.seconds);
    else pass_cnt++;
    total_cnt++;
    if ({bus.mode, bus.blink} !== 3'd0)
      $display("FAIL reset_mid_set_ctrl: got mode=%0d blink=%0d expected 0/0", bus.mode, bus.blink);
    else pass_cnt++;
    reset = 1'b0;
    step();
  endtask

  initial begin
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    test_reset();
    test_tick();
    test_set_hours();
    test_set_minutes();
    test_rollover();
    test_hold_through_reset();
    test_held_inc();
    test_reset_mid_set();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
